alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised multi-cycle ALU for the 65Org16/65Org32 cores. Holds the single-cycle add/sub/logic ops
//  and a barrel shifter. Adds iterative unsigned multiply and divide via a start/busy/done handshake.
//  Sits between the CPU register file and the ALU result/flag registers; RDY stalls it like the rest of the core.
// PARAMETERS
//  dw   16             data width (8, 16 or 32)
//  sw   $clog2(dw)     shift-amount width (derived; do not override)
// PORTS
//  clk      in   1      rising-edge clock
//  reset_n  in   1      synchronous, active-low reset
//  RDY      in   1      0 = stall: every register holds, including done
//  start    in   1      request; accepted on an edge with reset_n=1 & RDY=1 & busy=0
//  op       in   4      operation code (ALU_* in alu_pkg), sampled at accept
//  AI       in   dw     operand A, sampled at accept
//  BI       in   dw     operand B / divisor, sampled at accept
//  EI       in   sw     shift count, sampled at accept
//  CI       in   1      carry in, sampled at accept
//  busy     out  1      iterative op in progress
//  done     out  1      result valid; high 1 RDY-cycle after completion
//  OUT      out  dw     result: low product / quotient for MUL/DIV
//  OUT_HI   out  dw     high product / remainder; 0 for single-cycle ops
//  CO,V,Z,N out  1 ea   registered flags, all updated together with OUT
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, OUT=0, OUT_HI=0, CO=0, V=0, N=0, Z=1.
//   Reset low mid-operation aborts the op; no done is produced.
//  States: IDLE -> (accept of MULU/DIVU) RUN -> (step dw) IDLE. Single-cycle ops never leave IDLE.
//  done: set on the completing edge; cleared on the next RDY=1 edge unless that edge completes another op.
//  Back-to-back: start is accepted while done=1 and busy=0.
//  Single-cycle ops, latency 1 (accept edge loads OUT/flags; done=1 after it):
//   0000 ADD   {CO,OUT}=A+B+CI; V=signed overflow at bit dw-1
//   0001 SUB   {CO,OUT}=A+~B+CI; CO=1 means no borrow; V=signed overflow
//   0010 OR / 0011 AND / 0100 XOR / 0101 PASS A: CO=CI, V=0
//   0110 SHL   OUT=A<<EI; CO=A[dw-EI]
//   0111 SHR   OUT=A>>EI, zero fill; CO=A[EI-1]
//   1000 ASR   as SHR with sign fill from A[dw-1]
//   1001 ROL   rotate A left by EI, no carry path; CO=OUT[0]
//   For all shifts, EI=0 gives OUT=A and CO=CI.
//   1100-1111 reserved: behave as PASS A.
//  Iterative ops:
//   Accept edge loads operands, busy=1, count=dw-1. One step per RDY=1 edge.
//   Step dw (count=0) loads results, busy=0, done=1. Accept-to-done = dw RDY-edges.
//   1010 MULU  shift-add; {OUT_HI,OUT}=A*B; CO=(OUT_HI!=0); V=0
//   1011 DIVU  restoring; OUT=A/B, OUT_HI=A%B; CO=0; V=(B==0)
//    B==0 is not special-cased in the datapath; it yields OUT=all ones and OUT_HI=A.
//  Flags: single-cycle ops: Z=(OUT==0), N=OUT[dw-1].
//   MULU: Z=({OUT_HI,OUT}==0), N=OUT_HI[dw-1]. DIVU: Z=(OUT==0), N=OUT[dw-1].
//  start while busy=1 is ignored, with no queueing; op/operand changes during RUN have no effect.
//  OUT and flags hold their last values until the next completion.
// STRUCTURE
//  alu_pkg: ALU_* op localparams, state encoding {IDLE,RUN}, and an is_iter(op) function.
//  Sub-module alu_iter_core: shift-add/restore datapath with 2*dw accumulator, count and step enable.
//  alu_seq holds the FSM, the single-cycle datapath, and the output/flag registers.
// TESTING (dw=16)
//  ADD A=7FFF B=0001 CI=0 -> OUT=8000 CO=0 V=1 N=1 Z=0, done 1 cycle after accept
//  SUB A=0003 B=0005 CI=1 -> OUT=FFFE CO=0 V=0 N=1; ASR A=8001 EI=F -> OUT=FFFF CO=0
//  MULU A=FFFF B=FFFF -> after 16 edges OUT=0001 OUT_HI=FFFE CO=1; busy high exactly 16 cycles
//  DIVU A=1234 B=0000 -> OUT=FFFF OUT_HI=1234 V=1; DIVU A=0064 B=0007 -> OUT=000E OUT_HI=0002
//  MULU with RDY low for 5 cycles mid-run -> done at 16+5 cycles, same result; start while busy ignored
//  reset_n low at step 8 of DIVU -> next edge: busy=0 done=0 OUT=0 Z=1; a following ADD completes normally

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and op classification for the sequential ALU.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_OR   = 4'b0010;
    localparam logic [OP_W-1:0] ALU_AND  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [OP_W-1:0] ALU_PASS = 4'b0101;
    localparam logic [OP_W-1:0] ALU_SHL  = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SHR  = 4'b0111;
    localparam logic [OP_W-1:0] ALU_ASR  = 4'b1000;
    localparam logic [OP_W-1:0] ALU_ROL  = 4'b1001;
    localparam logic [OP_W-1:0] ALU_MULU = 4'b1010;
    localparam logic [OP_W-1:0] ALU_DIVU = 4'b1011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // True for ops that go through the multi-cycle datapath.
    function automatic logic is_iter(input logic [OP_W-1:0] op);
        return (op == ALU_MULU) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) datapath.
// Accumulator is {hi, lo}; one algorithm step per enabled edge.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int unsigned dw = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            step,
    input  logic [OP_W-1:0] op,
    input  logic [dw-1:0]   a,
    input  logic [dw-1:0]   b,
    output logic [dw-1:0]   hi_c,
    output logic [dw-1:0]   lo_c,
    output logic            last_c,
    output logic            div_c,
    output logic            bzero_c
);

    localparam int unsigned CW = (dw > 1) ? $clog2(dw) : 1;

    logic [2*dw-1:0] acc_q, acc_d, acc_step;
    logic [dw-1:0]   b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            div_q, div_d;

    logic [dw-1:0]   acc_hi, acc_lo;
    logic [dw:0]     mul_sum, div_rem, div_trial;
    logic [2*dw-1:0] mul_next, div_next;

    // One step of each algorithm computed from the current accumulator.
    always_comb begin
        acc_hi    = acc_q[2*dw-1:dw];
        acc_lo    = acc_q[dw-1:0];
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : (dw+1)'(0));
        mul_next  = {mul_sum, acc_lo[dw-1:1]};
        div_rem   = {acc_hi, acc_lo[dw-1]};
        div_trial = div_rem - {1'b0, b_q};
        // Remainder stays below the divisor, so trial bit dw is the borrow.
        if (!div_trial[dw]) begin
            div_next = {div_trial[dw-1:0], acc_lo[dw-2:0], 1'b1};
        end else begin
            div_next = {div_rem[dw-1:0], acc_lo[dw-2:0], 1'b0};
        end
        acc_step = div_q ? div_next : mul_next;
    end

    // Operand load on accept, otherwise advance when stepping.
    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        div_d = div_q;
        if (load) begin
            acc_d = {{dw{1'b0}}, a};
            b_d   = b;
            cnt_d = CW'(dw - 1);
            div_d = (op == ALU_DIVU);
        end else if (step) begin
            acc_d = acc_step;
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

    // Results are the post-step value so the final edge can capture them.
    assign hi_c    = acc_step[2*dw-1:dw];
    assign lo_c    = acc_step[dw-1:0];
    assign last_c  = (cnt_q == '0);
    assign div_c   = div_q;
    assign bzero_c = (b_q == '0);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus iterative
// MULU/DIVU behind a start/busy/done handshake. RDY low freezes everything.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned dw = 16,
    parameter int unsigned sw = $clog2(dw)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            RDY,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [dw-1:0]   AI,
    input  logic [dw-1:0]   BI,
    input  logic [sw-1:0]   EI,
    input  logic            CI,
    output logic            busy,
    output logic            done,
    output logic [dw-1:0]   OUT,
    output logic [dw-1:0]   OUT_HI,
    output logic            CO,
    output logic            V,
    output logic            Z,
    output logic            N
);

    state_t        state_q, state_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [dw-1:0] out_q, out_d, out_hi_q, out_hi_d;
    logic          co_q, co_d, v_q, v_d, z_q, z_d, n_q, n_d;

    logic          load_c, step_c;
    logic [dw-1:0] it_hi_c, it_lo_c;
    logic          it_last_c, it_div_c, it_bzero_c;

    logic [dw:0]   add_sum, sub_sum, shl_ext, shr_ext, asr_ext;
    logic [dw-1:0] rol_out, res_out;
    logic [sw-1:0] rol_back;
    logic          add_v, sub_v, res_co, res_v;

    alu_iter_core #(.dw(dw)) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_c),
        .step    (step_c),
        .op      (op),
        .a       (AI),
        .b       (BI),
        .hi_c    (it_hi_c),
        .lo_c    (it_lo_c),
        .last_c  (it_last_c),
        .div_c   (it_div_c),
        .bzero_c (it_bzero_c)
    );

    // Single-cycle datapath on the live operands.
    always_comb begin
        add_sum  = {1'b0, AI} + {1'b0, BI} + (dw+1)'(CI);
        sub_sum  = {1'b0, AI} + {1'b0, ~BI} + (dw+1)'(CI);
        add_v    = (AI[dw-1] == BI[dw-1]) && (add_sum[dw-1] != AI[dw-1]);
        sub_v    = (AI[dw-1] != BI[dw-1]) && (sub_sum[dw-1] != AI[dw-1]);
        // Extra bit on the shifted-out side carries the last bit shifted out.
        shl_ext  = {1'b0, AI} << EI;
        shr_ext  = {AI, 1'b0} >> EI;
        asr_ext  = $signed({AI, 1'b0}) >>> EI;
        // dw is a power of two, so -EI mod dw is the complementary rotate.
        rol_back = ~EI + sw'(1);
        rol_out  = (AI << EI) | (AI >> rol_back);

        res_out = AI;
        res_co  = CI;
        res_v   = 1'b0;
        case (op)
            ALU_ADD: begin
                {res_co, res_out} = add_sum;
                res_v             = add_v;
            end
            ALU_SUB: begin
                {res_co, res_out} = sub_sum;
                res_v             = sub_v;
            end
            ALU_OR:  res_out = AI | BI;
            ALU_AND: res_out = AI & BI;
            ALU_XOR: res_out = AI ^ BI;
            ALU_SHL: begin
                res_out = shl_ext[dw-1:0];
                res_co  = shl_ext[dw];
            end
            ALU_SHR: begin
                res_out = shr_ext[dw:1];
                res_co  = shr_ext[0];
            end
            ALU_ASR: begin
                res_out = asr_ext[dw:1];
                res_co  = asr_ext[0];
            end
            ALU_ROL: begin
                res_out = rol_out;
                res_co  = rol_out[0];
            end
            default: res_out = AI;
        endcase
        // A zero shift count passes carry through unchanged.
        if ((op inside {ALU_SHL, ALU_SHR, ALU_ASR, ALU_ROL}) && (EI == '0)) begin
            res_co = CI;
        end
    end

    // FSM next state, handshake and result/flag capture.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = done_q;
        out_d    = out_q;
        out_hi_d = out_hi_q;
        co_d     = co_q;
        v_d      = v_q;
        z_d      = z_q;
        n_d      = n_q;
        load_c   = 1'b0;
        step_c   = 1'b0;
        if (RDY) begin
            done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (is_iter(op)) begin
                            load_c  = 1'b1;
                            busy_d  = 1'b1;
                            state_d = ST_RUN;
                        end else begin
                            out_d    = res_out;
                            out_hi_d = '0;
                            co_d     = res_co;
                            v_d      = res_v;
                            z_d      = (res_out == '0);
                            n_d      = res_out[dw-1];
                            done_d   = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    step_c = 1'b1;
                    if (it_last_c) begin
                        state_d  = ST_IDLE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        out_d    = it_lo_c;
                        out_hi_d = it_hi_c;
                        if (it_div_c) begin
                            co_d = 1'b0;
                            v_d  = it_bzero_c;
                            z_d  = (it_lo_c == '0);
                            n_d  = it_lo_c[dw-1];
                        end else begin
                            co_d = (it_hi_c != '0);
                            v_d  = 1'b0;
                            z_d  = ({it_hi_c, it_lo_c} == '0);
                            n_d  = it_hi_c[dw-1];
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, handshake and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
            out_hi_q <= '0;
            co_q     <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b1;
            n_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            out_q    <= out_d;
            out_hi_q <= out_hi_d;
            co_q     <= co_d;
            v_q      <= v_d;
            z_q      <= z_d;
            n_q      <= n_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign OUT    = out_q;
    assign OUT_HI = out_hi_q;
    assign CO     = co_q;
    assign V      = v_q;
    assign Z      = z_q;
    assign N      = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (dw=16) with hand-computed expectations.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, RDY, start, CI;
    logic [3:0]  op, EI;
    logic [15:0] AI, BI;
    logic        busy, done, CO, V, Z, N;
    logic [15:0] OUT, OUT_HI;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.dw(16)) dut (
        .clk(clk), .reset_n(reset_n), .RDY(RDY), .start(start), .op(op),
        .AI(AI), .BI(BI), .EI(EI), .CI(CI), .busy(busy), .done(done),
        .OUT(OUT), .OUT_HI(OUT_HI), .CO(CO), .V(V), .Z(Z), .N(N)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [15:0] o, input logic [15:0] hi,
                             input logic co, input logic v, input logic z, input logic n);
        check({tag, ".OUT"}, 32'(OUT), 32'(o));
        check({tag, ".OUT_HI"}, 32'(OUT_HI), 32'(hi));
        check({tag, ".CO"}, 32'(CO), 32'(co));
        check({tag, ".V"}, 32'(V), 32'(v));
        check({tag, ".Z"}, 32'(Z), 32'(z));
        check({tag, ".N"}, 32'(N), 32'(n));
    endtask

    // Present a request for one edge; returns at the negedge after the accept edge.
    task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] e, input logic c);
        op = o; AI = a; BI = b; EI = e; CI = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count negedges while busy, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0; RDY = 1'b1; start = 1'b0; op = '0; AI = '0; BI = '0; EI = '0; CI = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check_res("rst", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single-cycle ops: done one edge after accept.
        issue(ALU_ADD, 16'h7FFF, 16'h0001, 4'h0, 1'b0);
        check("add.done", 32'(done), 32'd1);
        check("add.busy", 32'(busy), 32'd0);
        check_res("add", 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("add.done_clr", 32'(done), 32'd0);
        check("add.hold", 32'(OUT), 32'h8000);

        issue(ALU_SUB, 16'h0003, 16'h0005, 4'h0, 1'b1);
        check_res("sub", 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(ALU_ASR, 16'h8001, 16'h0000, 4'hF, 1'b1);
        check_res("asr", 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(ALU_SHL, 16'h8001, 16'h0000, 4'h1, 1'b0);
        check_res("shl", 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(ALU_ROL, 16'h8001, 16'h0000, 4'h4, 1'b1);
        check_res("rol", 16'h0018, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(ALU_SHR, 16'h00F1, 16'h0000, 4'h1, 1'b0);
        check_res("shr", 16'h0078, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(ALU_SHR, 16'h00F0, 16'h0000, 4'h0, 1'b1);
        check_res("shr0", 16'h00F0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(ALU_XOR, 16'hF0F0, 16'hFFFF, 4'h0, 1'b0);
        check_res("xor", 16'h0F0F, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(ALU_AND, 16'h00FF, 16'hFF00, 4'h0, 1'b1);
        check_res("and", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(4'hF, 16'hABCD, 16'h1111, 4'h0, 1'b0);
        check_res("rsvd", 16'hABCD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        // Back-to-back accept while done is high.
        issue(ALU_ADD, 16'hFFFF, 16'h0001, 4'h0, 1'b0);
        check("b2b.done", 32'(done), 32'd1);
        check_res("b2b", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        // MULU: busy for exactly 16 cycles, start during busy ignored.
        issue(ALU_MULU, 16'hFFFF, 16'hFFFF, 4'h0, 1'b0);
        check("mul.busy", 32'(busy), 32'd1);
        check("mul.done_lo", 32'(done), 32'd0);
        op = ALU_ADD; AI = 16'h0001; BI = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        check("mul.cycles", 32'(n + 1), 32'd16);
        check("mul.done", 32'(done), 32'd1);
        check_res("mul", 16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("mul.done_clr", 32'(done), 32'd0);

        // DIVU by zero and a normal divide.
        issue(ALU_DIVU, 16'h1234, 16'h0000, 4'h0, 1'b0);
        wait_idle(n);
        check("div0.cycles", 32'(n), 32'd16);
        check_res("div0", 16'hFFFF, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(ALU_DIVU, 16'h0064, 16'h0007, 4'h0, 1'b0);
        wait_idle(n);
        check("div.done", 32'(done), 32'd1);
        check_res("div", 16'h000E, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

        // MULU with RDY low for 5 cycles mid-run.
        issue(ALU_MULU, 16'hFFFF, 16'hFFFF, 4'h0, 1'b0);
        n = 0;
        while (!done && n < 100) begin
            RDY = (n < 3 || n >= 8);
            @(negedge clk);
            n++;
        end
        RDY = 1'b1;
        check("stall.cycles", 32'(n), 32'd21);
        check_res("stall", 16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
        RDY = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("stall.done_hold", 32'(done), 32'd1);
        RDY = 1'b1;
        @(negedge clk);
        check("stall.done_clr", 32'(done), 32'd0);

        // Reset at step 8 of DIVU aborts with no done.
        issue(ALU_DIVU, 16'h0064, 16'h0007, 4'h0, 1'b0);
        repeat (7) @(negedge clk);
        check("abort.busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.OUT", 32'(OUT), 32'h0000);
        check("abort.Z", 32'(Z), 32'd1);
        repeat (10) @(negedge clk);
        check("abort.no_done", 32'(done), 32'd0);
        issue(ALU_ADD, 16'h0001, 16'h0002, 4'h0, 1'b1);
        check("post.done", 32'(done), 32'd1);
        check_res("post", 16'h0004, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
